// File: rtl/cskip_result_fifo.sv
// cskip_result_fifo: result FIFO behind the 16-bit carry-skip adder.
// Captures {cout, sum} for each valid adder result, presents the head
// entry first-word-fall-through over valid/ready, counts carry-out events
// (saturating at 255) and flags results offered while full (sticky).
// Optional build macro: CSKIP_SAT_EN - store an all-ones sum when cout=1
// (saturating unsigned add); cout and ovf_cnt behave the same either way.
module cskip_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH:0]   out_data,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic [7:0]       ovf_cnt,
    output logic             drop_err
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic [WIDTH:0]  wdata;

    // Handshake flags and head entry come straight from registered state.
    always_comb begin
        in_ready  = (count != FULL_CNT);
        out_valid = (count != '0);
        out_data  = mem[rd_ptr];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Entry to store: raw sum, or all-ones sum on carry-out when saturating.
    always_comb begin
        wdata = {in_cout, in_sum};
`ifdef CSKIP_SAT_EN
        if (in_cout) begin
            wdata = {1'b1, {WIDTH{1'b1}}};
        end
`endif
    end

    // Storage array; written only on an accepted push outside reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy tracks push minus pop; simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Carry-out event counter (saturating) and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt  <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push && in_cout && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cskip_result_fifo.sv
// Self-checking bench for cskip_result_fifo: a reference queue holds the
// expected {cout, sum} entries, pushed when a result is accepted and
// popped when the consumer takes the head.
module tb_cskip_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH:0]   out_data;
    logic             out_ready;
    logic [AW:0]      count;
    logic [7:0]       ovf_cnt;
    logic             drop_err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] sb [$];
    int             m_ovf  = 0;
    logic           m_drop = 1'b0;

    cskip_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .ovf_cnt   (ovf_cnt),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic r, input logic iv, input logic [15:0] a,
                        input logic [15:0] b, input logic ordy);
        logic [16:0] full;
        logic [16:0] ent;
        logic        do_push;
        logic        do_pop;
        @(negedge clk);
        full      = {1'b0, a} + {1'b0, b};
        rst       = r;
        in_valid  = iv;
        in_sum    = full[15:0];
        in_cout   = full[16];
        out_ready = ordy;
        #1;
        check("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("count",     32'(count),     32'(sb.size()));
        check("ovf_cnt",   32'(ovf_cnt),   32'(m_ovf));
        check("drop_err",  32'(drop_err),  32'(m_drop));
        if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb[0]));
        end
        do_pop  = (sb.size() != 0) && ordy;
        do_push = iv && (sb.size() < DEPTH);
        ent = full;
`ifdef CSKIP_SAT_EN
        if (full[16]) begin
            ent = 17'h1FFFF;
        end
`endif
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_ovf  = 0;
            m_drop = 1'b0;
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
            end
            if (do_push) begin
                sb.push_back(ent);
                if (full[16] && m_ovf < 255) begin
                    m_ovf++;
                end
            end
            if (iv && !do_push) begin
                m_drop = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(0, 0, 16'h0, 16'h0, 1);

        // 1: simple result, one-cycle fall-through, then empty
        step(0, 1, 16'h0001, 16'h0002, 1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(out_data),  32'h00003);
        step(0, 0, 16'h0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // 2: carry-out result
        step(0, 1, 16'hFFFF, 16'h0001, 0);
`ifdef CSKIP_SAT_EN
        check("t2_data", 32'(out_data), 32'h1FFFF);
`else
        check("t2_data", 32'(out_data), 32'h10000);
`endif
        check("t2_ovf", 32'(ovf_cnt), 32'd1);
        step(0, 0, 16'h0, 16'h0, 1);

        // 3: fill to full, then offer a fifth result
        step(0, 1, 16'hAAAA, 16'h5555, 0);
        step(0, 1, 16'hF0F0, 16'h0F0F, 0);
        step(0, 1, 16'h1234, 16'h1111, 0);
        step(0, 1, 16'h8000, 16'h8001, 0);
        check("t3_count", 32'(count),    32'd4);
        check("t3_ready", 32'(in_ready), 32'd0);
        step(0, 1, 16'h7777, 16'h0001, 0);
        check("t3_drop",   32'(drop_err), 32'd1);
        check("t3_count2", 32'(count),    32'd4);
        check("t3_head",   32'(out_data), 32'h0FFFF);

        // 4: pop-only from full, then push+pop across pointer wrap, drain
        step(0, 1, 16'h0042, 16'h0000, 1);
        check("t4_count", 32'(count), 32'd3);
        step(0, 1, 16'h0100, 16'h0001, 1);
        check("t4_count2", 32'(count), 32'd3);
        repeat (4) step(0, 0, 16'h0, 16'h0, 1);
        check("t4_empty", 32'(count), 32'd0);

        // 5: many carry-outs while draining, counter saturates
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 16'hFFFF, 16'(i + 1), 1);
        end
        repeat (2) step(0, 0, 16'h0, 16'h0, 1);
        check("t5_ovf", 32'(ovf_cnt), 32'd255);

        // 6: reset with entries stored
        step(0, 1, 16'h0010, 16'h0001, 0);
        step(0, 1, 16'h0020, 16'h0002, 0);
        step(0, 1, 16'h0030, 16'h0003, 0);
        check("t6_count", 32'(count), 32'd3);
        step(1, 1, 16'h0040, 16'h0004, 1);
        check("t6_rcount", 32'(count),     32'd0);
        check("t6_rvalid", 32'(out_valid), 32'd0);
        check("t6_rdrop",  32'(drop_err),  32'd0);
        check("t6_rovf",   32'(ovf_cnt),   32'd0);
        check("t6_rready", 32'(in_ready),  32'd1);
        step(0, 0, 16'h0, 16'h0, 1);
        step(0, 1, 16'h0005, 16'h0006, 1);
        step(0, 0, 16'h0, 16'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
